pattern_frame_writer: RTL
=========================

Name: pattern_frame_writer

Overview:
- Parametrised successor to the fixed frame-buffer test-pattern generator: fills a frame buffer of NUM_WORDS words with a selectable test pattern.
- Drives a valid/ready write port with backpressure, plus start/busy/done control, single-shot or continuous frames, and abort.
- Sits between the control register block and the frame-buffer write port.

Parameters:
- ADDR_W, 16, width of wr_addr.
- DATA_W, 16, width of wr_data.
- NUM_WORDS, 24000, words per frame; range 2..2^ADDR_W.
- PERIOD, 50, stripe/checker period in words; must be ≥1.
- FG, all ones (DATA_W bits), foreground word.
- BG, 0, background word.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- abort  in  1  stops the current frame.
- mode  in  2  pattern select, sampled on an accepted start.
- repeat_en  in  1  continuous-frame enable, sampled on an accepted start.
- wr_addr  out  ADDR_W  frame-buffer word address.
- wr_data  out  DATA_W  pattern word.
- wr_valid  out  1  write request.
- wr_ready  in  1  frame buffer accepts the write.
- busy  out  1  high in WRITE.
- done  out  1  one-cycle pulse when a single-shot frame completes.
- frame_cnt  out  16  completed frames, wraps at 16'hFFFF→0.

Behaviour:
- All outputs are registered.
- Reset values: wr_addr=0, wr_data=0, wr_valid=0, busy=0, done=0, frame_cnt=0, state=IDLE. Reset overrides every other input, including mid-frame.
- States:
  - IDLE: wr_valid=0, busy=0. start=1 → WRITE. On that edge: latch mode and repeat_en, wr_addr=0, wr_data=pattern(0), phase counter=0, stripe-phase=0, wr_valid=1, busy=1. The first write is presented 1 cycle after start.
  - WRITE:
    - A transfer is wr_valid & wr_ready on a rising edge.
    - While wr_ready=0, wr_addr and wr_data hold stable.
    - On a transfer with wr_addr<NUM_WORDS-1: wr_addr+1; wr_data=pattern(next addr) in the same edge. There are no bubbles under continuous ready.
    - On a transfer with wr_addr=NUM_WORDS-1: frame_cnt+1.
      - repeat latched: wr_addr=0, counters cleared, stay in WRITE, wr_valid stays 1.
      - repeat not latched: → DONE, wr_valid=0, busy=0, done=1.
  - DONE: lasts 1 cycle, done=1, then → IDLE with done=0.
- Abort:
  - In WRITE, abort=1 → IDLE next edge; wr_valid=0, busy=0, done stays 0, frame_cnt unchanged.
  - If abort coincides with the final transfer, the transfer completes and frame_cnt increments, but abort wins: → IDLE, no done pulse, no repeat.
- start while busy or in DONE: ignored; mode and repeat_en are not re-sampled.
- start and abort together in IDLE: abort wins, stays IDLE.
- Patterns, p = word address:
  - mode 0 (solid): FG.
  - mode 1 (stripe): FG when p mod PERIOD = 0, else BG.
  - mode 2 (checker): FG when floor(p/PERIOD) is even, else BG.
  - mode 3 (ramp): p zero-extended or truncated to DATA_W.
- Implementation constraint: no divider or modulo hardware. Use a phase counter 0..PERIOD-1 that advances on each transfer and wraps to 0. Use a stripe-phase bit that toggles on each phase wrap. Both clear at frame start.

Test Plan (NUM_WORDS=8, PERIOD=3, DATA_W=16 unless stated):
- Reset mid-WRITE at wr_addr=5 → next cycle wr_valid=0, busy=0, wr_addr=0, frame_cnt=0. A new start restarts from addr 0.
- mode=1, wr_ready=1, start → addrs 0..7 on 8 consecutive cycles; data FG,BG,BG,FG,BG,BG,FG,BG. done pulses 1 cycle after addr 7, exactly 1 cycle wide. frame_cnt=1.
- mode=2 with wr_ready toggling 1/0 → each addr/data held while ready=0. Data per addr 0..7 = FG,FG,FG,BG,BG,BG,FG,FG. Total 8 transfers.
- mode=3, repeat_en=1 → addr sequence 0..7,0..7; data equals addr. frame_cnt 1 then 2 at each wrap. No done. busy stays high. Abort → IDLE, wr_valid low next cycle.
- Abort asserted on the addr-7 transfer in single-shot → frame_cnt increments, done never pulses, state IDLE.
- start during WRITE with a different mode → ignored, pattern unchanged. Default parameters, mode=1, full ready → 24000 transfers, FG at addrs 0,50,100,…,23950, done pulse.

Source files
------------

// File: rtl/pattern_frame_writer.sv
// Fills a frame buffer with a selectable test pattern (solid, stripe, checker, ramp)
// over a valid/ready write port, with single-shot or continuous frames and abort.
module pattern_frame_writer #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter int                NUM_WORDS = 24000,
  parameter int                PERIOD    = 50,
  parameter logic [DATA_W-1:0] FG        = '1,
  parameter logic [DATA_W-1:0] BG        = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [1:0]        mode_i,
  input  logic              repeat_en_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int                PH_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PERIOD - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [1:0]        mode_q;
  logic              repeat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       frame_cnt_q;
  logic [PH_W-1:0]   phase_q;
  logic              stripe_q;

  logic              xfer_d;
  logic              last_d;
  logic              phase_wrap_d;
  logic [PH_W-1:0]   phase_d;
  logic              stripe_d;
  logic [ADDR_W-1:0] addr_d;

  // phase_q tracks addr mod PERIOD and stripe_q tracks floor(addr/PERIOD) parity,
  // so the checker and stripe patterns need no divider.
  function automatic logic [DATA_W-1:0] pattern_word(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] a,
    input logic              ph_zero,
    input logic              stripe
  );
    logic [DATA_W-1:0] w;
    case (m)
      2'd0:    w = FG;
      2'd1:    w = ph_zero ? FG : BG;
      2'd2:    w = stripe ? BG : FG;
      default: w = DATA_W'(a);
    endcase
    return w;
  endfunction

  always_comb begin
    xfer_d       = valid_q & wr_ready_i;
    last_d       = (addr_q == ADDR_LAST);
    phase_wrap_d = (phase_q == PH_LAST);
    phase_d      = phase_wrap_d ? '0 : phase_q + PH_W'(1);
    stripe_d     = stripe_q ^ phase_wrap_d;
    addr_d       = addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'd0;
      repeat_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      phase_q     <= '0;
      stripe_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            state_q  <= ST_WRITE;
            mode_q   <= mode_i;
            repeat_q <= repeat_en_i;
            addr_q   <= '0;
            data_q   <= pattern_word(mode_i, '0, 1'b1, 1'b0);
            phase_q  <= '0;
            stripe_q <= 1'b0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_WRITE: begin
          // The final transfer still counts even when abort arrives with it.
          if (xfer_d && last_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
          if (abort_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (xfer_d) begin
            if (last_d) begin
              if (repeat_q) begin
                addr_q   <= '0;
                data_q   <= pattern_word(mode_q, '0, 1'b1, 1'b0);
                phase_q  <= '0;
                stripe_q <= 1'b0;
              end else begin
                state_q <= ST_DONE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              addr_q   <= addr_d;
              data_q   <= pattern_word(mode_q, addr_d, (phase_d == '0), stripe_d);
              phase_q  <= phase_d;
              stripe_q <= stripe_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign wr_valid_o  = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
